rx_baud_generator: RTL and testbench

Generates the receive bit-sample strobe `BITCLK` consumed by the eUSCI UART receive state machine. The block is phase-locked to the start-bit detect enable `RxBEN`. The first strobe lands mid-start-bit and each following strobe lands mid-bit one bit period later. Bit period follows the eUSCI_A baud settings (UCBRx, UCOS16, UCBRFx, UCBRSx) with BRCLK = MCLK.

---
 rtl/rx_baud_generator_if.sv | 23 ++
 rtl/rx_baud_generator.sv | 138 +++++++++++++
 tb/tb_rx_baud_generator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_baud_generator_if.sv
// Receive baud generator bus: eUSCI control/config toward the generator,
// sample strobe and status back to the receive state machine.
interface rx_baud_generator_if;
    logic        wUCSWRST;
    logic        RxBEN;
    logic        wUCOS16;
    logic [15:0] wUCBR;
    logic [3:0]  wUCBRF;
    logic [7:0]  wUCBRS;
    logic        BITCLK;
    logic        Running;
    logic [2:0]  BitIdx;

    modport master (
        output wUCSWRST, RxBEN, wUCOS16, wUCBR, wUCBRF, wUCBRS,
        input  BITCLK, Running, BitIdx
    );

    modport slave (
        input  wUCSWRST, RxBEN, wUCOS16, wUCBR, wUCBRF, wUCBRS,
        output BITCLK, Running, BitIdx
    );
endinterface

// File: rtl/rx_baud_generator.sv
// eUSCI UART receive bit-sample strobe generator. Phase-locks to RxBEN,
// emits the first strobe mid-start-bit, then one strobe per bit period.
// Each interval is built from sub-periods: one per interval in
// low-frequency mode, 8 (half) or 16 (full) in oversampling mode.
module rx_baud_generator (
    input  logic                MCLK,
    input  logic                reset,
    rx_baud_generator_if.slave  bus
);
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_HALF = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic        os_q,     os_d;
    logic [15:0] b_q,      b_d;
    logic [3:0]  f_q,      f_d;
    logic [7:0]  s_q,      s_d;
    logic [16:0] rem_q,    rem_d;   // cycles left in current sub-period, minus one
    logic [3:0]  j_q,      j_d;     // sub-period index within the interval
    logic [2:0]  k_q,      k_d;     // full-interval index mod 8
    logic        bitclk_q, bitclk_d;

    logic [15:0] b_in;
    logic        en;
    logic        last_sub;
    logic [2:0]  k_next;

    // Length in cycles of sub-period j of the half or full interval k.
    // Max value is 65536, so 17 bits never overflow.
    function automatic logic [16:0] sub_len(
        input logic        os,
        input logic [15:0] b,
        input logic [3:0]  f,
        input logic [7:0]  s,
        input logic        half,
        input logic [3:0]  j,
        input logic [2:0]  k
    );
        logic [16:0] len;
        if (!os) begin
            if (half)
                len = (b[15:1] == 15'd0) ? 17'd1 : {2'b00, b[15:1]};
            else
                len = {1'b0, b} + {16'd0, s[k]};
        end else begin
            len = {1'b0, b} + {16'd0, (j < f)}
                + {16'd0, (!half && j == 4'd15 && s[k])};
        end
        return len;
    endfunction

    assign b_in     = (bus.wUCBR == 16'd0) ? 16'd1 : bus.wUCBR;
    assign en       = bus.RxBEN && !bus.wUCSWRST;
    assign last_sub = !os_q || ((state_q == S_HALF) ? (j_q == 4'd7) : (j_q == 4'd15));
    assign k_next   = (state_q == S_HALF) ? 3'd0 : k_q + 3'd1;

    // Next-state: abort first, then start/count/expire per state.
    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        b_d      = b_q;
        f_d      = f_q;
        s_d      = s_q;
        rem_d    = rem_q;
        j_d      = j_q;
        k_d      = k_q;
        bitclk_d = 1'b0;
        if (!en) begin
            state_d = S_OFF;
            rem_d   = 17'd0;
            j_d     = 4'd0;
            k_d     = 3'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    // Config is captured here and held for the whole character.
                    state_d = S_HALF;
                    os_d    = bus.wUCOS16;
                    b_d     = b_in;
                    f_d     = bus.wUCBRF;
                    s_d     = bus.wUCBRS;
                    j_d     = 4'd0;
                    k_d     = 3'd0;
                    rem_d   = sub_len(bus.wUCOS16, b_in, bus.wUCBRF, bus.wUCBRS,
                                      1'b1, 4'd0, 3'd0) - 17'd1;
                end
                S_HALF, S_RUN: begin
                    if (rem_q == 17'd0) begin
                        if (last_sub) begin
                            bitclk_d = 1'b1;
                            state_d  = S_RUN;
                            k_d      = k_next;
                            j_d      = 4'd0;
                            rem_d    = sub_len(os_q, b_q, f_q, s_q, 1'b0, 4'd0, k_next) - 17'd1;
                        end else begin
                            j_d   = j_q + 4'd1;
                            rem_d = sub_len(os_q, b_q, f_q, s_q, state_q == S_HALF,
                                            j_q + 4'd1, k_q) - 17'd1;
                        end
                    end else begin
                        rem_d = rem_q - 17'd1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q  <= S_OFF;
            os_q     <= 1'b0;
            b_q      <= 16'd0;
            f_q      <= 4'd0;
            s_q      <= 8'd0;
            rem_q    <= 17'd0;
            j_q      <= 4'd0;
            k_q      <= 3'd0;
            bitclk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            b_q      <= b_d;
            f_q      <= f_d;
            s_q      <= s_d;
            rem_q    <= rem_d;
            j_q      <= j_d;
            k_q      <= k_d;
            bitclk_q <= bitclk_d;
        end
    end

    assign bus.BITCLK  = bitclk_q;
    assign bus.Running = (state_q != S_OFF);
    assign bus.BitIdx  = k_q;
endmodule

// File: tb/tb_rx_baud_generator.sv
// Bench for rx_baud_generator: directed plan steps plus random characters,
// every cycle compared against an interval-arithmetic reference model.
module tb_rx_baud_generator;
    logic MCLK = 1'b0;
    logic reset;
    rx_baud_generator_if bus();

    rx_baud_generator dut (.MCLK(MCLK), .reset(reset), .bus(bus));

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since E0, time of next pulse, pulses so far.
    bit          m_act = 0;
    int          m_n, m_next, m_pulses;
    bit          m_os;
    int          m_b, m_f;
    logic [7:0]  m_s;
    int          pq[$];   // observed DUT pulse times, relative to E0

    function automatic int half_len(bit os, int b, int f);
        if (os) return 8 * b + ((f < 8) ? f : 8);
        return ((b / 2) < 1) ? 1 : b / 2;
    endfunction

    function automatic int full_len(bit os, int b, int f, logic [7:0] s, int k);
        logic [7:0] sv;
        sv = s;
        return (os ? 16 * b + f : b) + int'(sv[k]);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pq_at(int i);
        return (i < pq.size()) ? pq[i] : -1;
    endfunction

    // One clock: sample inputs as the DUT will, advance model, compare at negedge.
    task automatic tick();
        bit r, en, exp_bc;
        int idx, obs, exp;
        r  = reset;
        en = bus.RxBEN && !bus.wUCSWRST;
        @(posedge MCLK);
        @(negedge MCLK);
        exp_bc = 0;
        if (r || !en) begin
            m_act = 0;
        end else if (!m_act) begin
            m_act    = 1;
            m_n      = 0;
            m_os     = bus.wUCOS16;
            m_b      = (bus.wUCBR == 16'd0) ? 1 : int'(bus.wUCBR);
            m_f      = int'(bus.wUCBRF);
            m_s      = bus.wUCBRS;
            m_next   = half_len(m_os, m_b, m_f);
            m_pulses = 0;
        end else begin
            m_n++;
            if (m_n == m_next) begin
                exp_bc = 1;
                m_next += full_len(m_os, m_b, m_f, m_s, m_pulses % 8);
                m_pulses++;
            end
        end
        idx = (m_act && m_pulses > 0) ? (m_pulses - 1) % 8 : 0;
        exp = {27'd0, exp_bc, m_act, idx[2:0]};
        obs = {27'd0, bus.BITCLK, bus.Running, bus.BitIdx};
        if (bus.BITCLK === 1'b1 && m_act) pq.push_back(m_n);
        chk($sformatf("cycle n=%0d {BITCLK,Running,BitIdx}", m_n), obs, exp);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(bit os, logic [15:0] br, logic [3:0] f, logic [7:0] s);
        bus.wUCOS16 = os;
        bus.wUCBR   = br;
        bus.wUCBRF  = f;
        bus.wUCBRS  = s;
    endtask

    task automatic start_char();
        pq.delete();
        bus.RxBEN = 1'b1;
    endtask

    task automatic end_char(int n);
        bus.RxBEN = 1'b0;
        run(n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp7[9];
        reset = 1'b1;
        bus.RxBEN = 1'b0;
        bus.wUCSWRST = 1'b0;
        set_cfg(0, 16'd0, 4'd0, 8'd0);
        @(negedge MCLK);
        run(2);
        chk("reset_outputs", {bus.BITCLK, bus.Running, bus.BitIdx}, 0);
        reset = 1'b0;
        run(2);

        // Low-frequency unmodulated
        set_cfg(0, 16'd6, 4'd0, 8'h00);
        start_char();
        run(30);
        chk("lf_p0", pq_at(0), 3);
        chk("lf_p1", pq_at(1), 9);
        chk("lf_p2", pq_at(2), 15);
        chk("lf_p3", pq_at(3), 21);
        end_char(3);

        // Low-frequency modulated, BitIdx wraps
        set_cfg(0, 16'd6, 4'd0, 8'h81);
        start_char();
        run(75);
        exp7 = '{7, 6, 6, 6, 6, 6, 6, 7, 7};
        for (int i = 0; i < 9; i++)
            chk($sformatf("lfmod_int%0d", i), pq_at(i + 1) - pq_at(i), exp7[i]);
        end_char(3);

        // Oversampling with modulation
        set_cfg(1, 16'd1, 4'd4, 8'h80);
        start_char();
        run(200);
        chk("os_half", pq_at(0), 12);
        chk("os_k0", pq_at(1) - pq_at(0), 20);
        chk("os_k6", pq_at(7) - pq_at(6), 20);
        chk("os_k7", pq_at(8) - pq_at(7), 21);
        chk("os_k0b", pq_at(9) - pq_at(8), 20);
        end_char(3);

        set_cfg(1, 16'd1, 4'd0, 8'h00);
        start_char();
        run(30);
        chk("os_plain_half", pq_at(0), 8);
        chk("os_plain_full", pq_at(1) - pq_at(0), 16);
        end_char(3);

        // Abort on the expiring edge, then re-lock 5 cycles later
        set_cfg(0, 16'd6, 4'd0, 8'h00);
        start_char();
        run(9);                      // edges n=0..8
        bus.RxBEN = 1'b0;            // edge n=9 would pulse
        tick();
        chk("abort_bitclk", int'(bus.BITCLK), 0);
        chk("abort_running", int'(bus.Running), 0);
        run(4);
        start_char();
        run(10);
        chk("relock_p0", pq_at(0), 3);
        end_char(2);

        // Config latched for the whole character
        set_cfg(0, 16'd6, 4'd0, 8'h00);
        start_char();
        run(5);
        bus.wUCBR = 16'd10;
        run(20);
        chk("latch_int0", pq_at(1) - pq_at(0), 6);
        chk("latch_int1", pq_at(2) - pq_at(1), 6);
        end_char(2);
        start_char();
        run(30);
        chk("latch_new_p0", pq_at(0), 5);
        chk("latch_new_int", pq_at(1) - pq_at(0), 10);

        // Reset mid-run
        reset = 1'b1;
        tick();
        chk("midreset_outputs", {bus.BITCLK, bus.Running, bus.BitIdx}, 0);
        reset = 1'b0;
        end_char(2);

        // wUCBR=0 behaves as 1
        set_cfg(0, 16'd0, 4'd0, 8'h00);
        start_char();
        run(6);
        chk("b0_p0", pq_at(0), 1);
        chk("b0_p1", pq_at(1), 2);
        chk("b0_p3", pq_at(3), 4);
        end_char(2);

        // Software reset blocks start
        bus.wUCSWRST = 1'b1;
        start_char();
        run(5);
        chk("swrst_running", int'(bus.Running), 0);
        bus.wUCSWRST = 1'b0;
        end_char(2);

        // Maximum prescaler: long half interval, no counter wrap
        set_cfg(0, 16'hFFFF, 4'd0, 8'hFF);
        start_char();
        run(32767 + 1000);
        chk("bmax_half", pq_at(0), 32767);
        chk("bmax_count", pq.size(), 1);
        end_char(2);

        // Random characters with occasional mid-character config and swrst changes
        for (int it = 0; it < 40; it++) begin
            set_cfg(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)),
                    4'($urandom_range(0, 15)), 8'($urandom));
            start_char();
            run($urandom_range(5, 120));
            if ($urandom_range(0, 3) == 0) begin
                set_cfg(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)),
                        4'($urandom_range(0, 15)), 8'($urandom));
                run($urandom_range(5, 60));
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.wUCSWRST = 1'b1;
                run($urandom_range(1, 3));
                bus.wUCSWRST = 1'b0;
                run($urandom_range(5, 40));
            end
            end_char($urandom_range(1, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
